// File: rtl/alu_cmd_sequencer.sv
// Command front-end for a W-bit combinational ALU: registers the ALU drive, captures
// results with flags, and adds a multi-cycle multiply built from repeated ALU adds.
module alu_cmd_sequencer #(
   parameter int unsigned W     = 4,
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [W-1:0]     cmd_a,
   input  logic [W-1:0]     cmd_b,
   output logic [1:0]       alu_control,
   output logic [W-1:0]     alu_a,
   output logic [W-1:0]     alu_b,
   input  logic [W-1:0]     alu_result,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [W-1:0]     res_data,
   output logic             res_zero,
   output logic             res_neg,
   output logic             res_err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_MUL  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [2:0] OP_MUL   = 3'b100;
   localparam logic [1:0] CTL_ADD  = 2'b00;
   localparam logic [1:0] CTL_ZERO = 2'b11;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic [W-1:0]         mcand_q, mcand_d;
   logic [1:0]           ctl_d;
   logic [W-1:0]         alu_a_d, alu_b_d;
   logic [W-1:0]         res_data_d;
   logic                 res_err_d;

   // Next-state and next-register values; everything defaults to hold.
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      mcand_d    = mcand_q;
      ctl_d      = alu_control;
      alu_a_d    = alu_a;
      alu_b_d    = alu_b;
      res_data_d = res_data;
      res_err_d  = res_err;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               mcand_d = cmd_a;
               if (!cmd_op[2]) begin
                  state_d = S_EXEC;
                  ctl_d   = cmd_op[1:0];
                  alu_a_d = cmd_a;
                  alu_b_d = cmd_b;
               end else if (cmd_op == OP_MUL) begin
                  if (cmd_b == '0) begin
                     state_d    = S_DONE;
                     res_data_d = '0;
                     res_err_d  = 1'b0;
                  end else begin
                     state_d = S_MUL;
                     count_d = CNT_W'(cmd_b);
                     ctl_d   = CTL_ADD;
                     alu_a_d = '0;
                     alu_b_d = cmd_a;
                  end
               end else begin
                  state_d    = S_DONE;
                  res_data_d = '0;
                  res_err_d  = 1'b1;
               end
            end
         end
         S_EXEC: begin
            state_d    = S_DONE;
            res_data_d = alu_result;
            res_err_d  = 1'b0;
            ctl_d      = CTL_ZERO;
            alu_a_d    = '0;
            alu_b_d    = '0;
         end
         S_MUL: begin
            // alu_a doubles as the running accumulator fed back through the adder.
            alu_a_d = alu_result;
            alu_b_d = mcand_q;
            count_d = count_q - CNT_W'(1);
            if (count_q == CNT_W'(1)) begin
               state_d    = S_DONE;
               res_data_d = alu_result;
               res_err_d  = 1'b0;
               ctl_d      = CTL_ZERO;
               alu_a_d    = '0;
               alu_b_d    = '0;
            end
         end
         S_DONE: begin
            if (res_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, datapath and output registers; handshake outputs follow the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         count_q     <= '0;
         mcand_q     <= '0;
         alu_control <= CTL_ZERO;
         alu_a       <= '0;
         alu_b       <= '0;
         res_data    <= '0;
         res_zero    <= 1'b1;
         res_neg     <= 1'b0;
         res_err     <= 1'b0;
         cmd_ready   <= 1'b1;
         res_valid   <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         mcand_q     <= mcand_d;
         alu_control <= ctl_d;
         alu_a       <= alu_a_d;
         alu_b       <= alu_b_d;
         res_data    <= res_data_d;
         res_zero    <= (res_data_d == '0);
         res_neg     <= res_data_d[W-1];
         res_err     <= res_err_d;
         cmd_ready   <= (state_d == S_IDLE);
         res_valid   <= (state_d == S_DONE);
      end
   end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer with an attached behavioural ALU and a
// reference model computing result, flags, error and latency from the command alone.
module tb_alu_cmd_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid, cmd_ready;
   logic [2:0] cmd_op;
   logic [3:0] cmd_a, cmd_b;
   logic [1:0] alu_control;
   logic [3:0] alu_a, alu_b, alu_result;
   logic       res_valid, res_ready;
   logic [3:0] res_data;
   logic       res_zero, res_neg, res_err;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   alu_cmd_sequencer #(.W(4), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_a(cmd_a), .cmd_b(cmd_b),
      .alu_control(alu_control), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_zero(res_zero), .res_neg(res_neg), .res_err(res_err)
   );

   // The downstream combinational ALU.
   always_comb begin
      case (alu_control)
         2'b00:   alu_result = alu_a + alu_b;
         2'b01:   alu_result = alu_a - alu_b;
         2'b10:   alu_result = ~alu_b;
         default: alu_result = 4'h0;
      endcase
   end

   // Expected {latency[7:0], data, zero, neg, err, busy_ok} for one command.
   task automatic model(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                        output logic [15:0] exp);
      int r;
      int l;
      logic e;
      logic [3:0] d;
      e = 1'b0;
      case (op)
         3'd0: r = int'(a) + int'(b);
         3'd1: r = int'(a) - int'(b);
         3'd2: r = 15 - int'(b);
         3'd3: r = 0;
         3'd4: r = int'(a) * int'(b);
         default: begin r = 0; e = 1'b1; end
      endcase
      if (op < 3'd4)       l = 2;
      else if (op == 3'd4) l = 1 + int'(b);
      else                 l = 1;
      d = 4'(r);
      exp = {8'(l), d, (d == 4'h0), d[3], e, 1'b1};
   endtask

   // Issue one command and wait for its result; returns the observed vector and the
   // ALU control seen one cycle after acceptance. Leaves the result pending.
   task automatic run_cmd(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                          output logic [15:0] obs, output logic [1:0] ctl1);
      int w;
      int lat;
      logic busy_ok;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
      w = 0;
      while (!cmd_ready && w < 50) begin @(negedge clk); w++; end
      @(negedge clk);
      cmd_valid = 1'b0;
      ctl1 = alu_control;
      lat = 1;
      busy_ok = 1'b1;
      while (!res_valid && lat < 40) begin
         if (cmd_ready) busy_ok = 1'b0;
         @(negedge clk);
         lat++;
      end
      if (cmd_ready) busy_ok = 1'b0;
      if (w >= 50) lat = 255;
      obs = {8'(lat), res_data, res_zero, res_neg, res_err, busy_ok};
   endtask

   // Complete the result handshake; returns {res_valid, cmd_ready} the cycle after.
   task automatic release_res(output logic [1:0] after);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      after = {res_valid, cmd_ready};
   endtask

   task automatic test_reset;
      logic [21:0] rst_vec;
      logic ok;
      rst_vec = {1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 2'b11, 4'h0, 4'h0};
      n_checks++;
      if ({cmd_ready, res_valid, res_data, res_zero, res_neg, res_err, alu_control, alu_a, alu_b} !== rst_vec)
         $display("FAIL reset_values: got %h want %h",
                  {cmd_ready, res_valid, res_data, res_zero, res_neg, res_err, alu_control, alu_a, alu_b}, rst_vec);
      else n_pass++;
      // Start mul 3*7, then reset during the third iteration.
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 3'b100; cmd_a = 4'd3; cmd_b = 4'd7;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({cmd_ready, res_valid, res_data, res_zero, res_neg, res_err, alu_control, alu_a, alu_b} !== rst_vec)
         $display("FAIL reset_mid_mul: got %h want %h",
                  {cmd_ready, res_valid, res_data, res_zero, res_neg, res_err, alu_control, alu_a, alu_b}, rst_vec);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      ok = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (!cmd_ready || res_valid) ok = 1'b0;
      end
      n_checks++;
      if (ok !== 1'b1) $display("FAIL reset_release_idle: got ready=%b valid=%b want ready=1 valid=0", cmd_ready, res_valid);
      else n_pass++;
   endtask

   task automatic test_alu_ops;
      logic [15:0] obs, exp;
      logic [1:0] ctl1, after;
      logic [2:0] op;
      logic [3:0] a, b;
      for (int i = 0; i < 14; i++) begin
         if (i == 0)      begin op = 3'd0; a = 4'd7; b = 4'd5; end
         else if (i == 1) begin op = 3'd1; a = 4'd3; b = 4'd5; end
         else begin op = 3'($urandom_range(0, 3)); a = 4'($urandom); b = 4'($urandom); end
         model(op, a, b, exp);
         run_cmd(op, a, b, obs, ctl1);
         n_checks++;
         if (obs !== exp) $display("FAIL alu_op%0d_%0d_%0d: got %h want %h", op, a, b, obs, exp);
         else n_pass++;
         n_checks++;
         if (ctl1 !== op[1:0]) $display("FAIL alu_ctl_op%0d: got %b want %b", op, ctl1, op[1:0]);
         else n_pass++;
         release_res(after);
         n_checks++;
         if (after !== 2'b01) $display("FAIL alu_release: got %b want 01", after);
         else n_pass++;
      end
   endtask

   task automatic test_mul;
      logic [15:0] obs, exp;
      logic [1:0] ctl1, after;
      logic [2:0] op;
      logic [3:0] a, b;
      for (int i = 0; i < 12; i++) begin
         op = 3'd4;
         case (i)
            0: begin a = 4'd3; b = 4'd5; end
            1: begin a = 4'd5; b = 4'd4; end
            2: begin a = 4'd9; b = 4'd0; end
            3: begin op = 3'd3; a = 4'd6; b = 4'd9; end
            4: begin a = 4'd15; b = 4'd15; end
            5: begin a = 4'd7; b = 4'd1; end
            default: begin a = 4'($urandom); b = 4'($urandom); end
         endcase
         model(op, a, b, exp);
         run_cmd(op, a, b, obs, ctl1);
         n_checks++;
         if (obs !== exp) $display("FAIL mul_op%0d_%0d_%0d: got %h want %h", op, a, b, obs, exp);
         else n_pass++;
         release_res(after);
         n_checks++;
         if (after !== 2'b01) $display("FAIL mul_release: got %b want 01", after);
         else n_pass++;
      end
   endtask

   task automatic test_illegal;
      logic [15:0] obs, exp;
      logic [1:0] ctl1, after;
      logic [2:0] op;
      logic [3:0] a, b;
      for (int i = 0; i < 6; i++) begin
         if (i == 0)            begin op = 3'b110; a = 4'd4; b = 4'd9; end
         else if (i % 2 == 1)   begin op = 3'd0; a = 4'd1; b = 4'd1; end
         else begin op = 3'($urandom_range(5, 7)); a = 4'($urandom); b = 4'($urandom); end
         model(op, a, b, exp);
         run_cmd(op, a, b, obs, ctl1);
         n_checks++;
         if (obs !== exp) $display("FAIL illegal_seq_op%0d: got %h want %h", op, obs, exp);
         else n_pass++;
         release_res(after);
      end
   endtask

   task automatic test_backpressure;
      logic [15:0] obs, exp;
      logic [1:0] ctl1, after;
      logic ok;
      model(3'd0, 4'd2, 4'd2, exp);
      run_cmd(3'd0, 4'd2, 4'd2, obs, ctl1);
      n_checks++;
      if (obs !== exp) $display("FAIL bp_add: got %h want %h", obs, exp);
      else n_pass++;
      // Pending command presented while the result is back-pressured.
      cmd_valid = 1'b1; cmd_op = 3'd0; cmd_a = 4'd1; cmd_b = 4'd2;
      ok = 1'b1;
      repeat (5) begin
         @(negedge clk);
         if ({res_valid, res_data, res_zero, res_neg, res_err, cmd_ready} !== {1'b1, 4'd4, 3'b000, 1'b0}) ok = 1'b0;
      end
      n_checks++;
      if (ok !== 1'b1) $display("FAIL bp_stable: got valid=%b data=%0d ready=%b want 1/4/0", res_valid, res_data, cmd_ready);
      else n_pass++;
      release_res(after);
      n_checks++;
      if (after !== 2'b01) $display("FAIL bp_release: got %b want 01", after);
      else n_pass++;
      @(negedge clk);
      cmd_valid = 1'b0;
      n_checks++;
      if ({cmd_ready, alu_control, alu_a, alu_b} !== {1'b0, 2'b00, 4'd1, 4'd2})
         $display("FAIL bp_pending_accept: got %h want %h", {cmd_ready, alu_control, alu_a, alu_b}, {1'b0, 2'b00, 4'd1, 4'd2});
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if ({res_valid, res_data, res_err} !== {1'b1, 4'd3, 1'b0})
         $display("FAIL bp_pending_result: got %h want %h", {res_valid, res_data, res_err}, {1'b1, 4'd3, 1'b0});
      else n_pass++;
      release_res(after);
   endtask

   task automatic test_back_to_back;
      logic [15:0] obs, exp;
      logic [1:0] ctl1, after;
      logic [2:0] op;
      logic [3:0] a, b;
      logic [5:0] held;
      logic ok;
      for (int i = 0; i < 30; i++) begin
         op = 3'($urandom_range(0, 7)); a = 4'($urandom); b = 4'($urandom);
         model(op, a, b, exp);
         run_cmd(op, a, b, obs, ctl1);
         n_checks++;
         if (obs !== exp) $display("FAIL b2b_op%0d_%0d_%0d: got %h want %h", op, a, b, obs, exp);
         else n_pass++;
         held = {res_valid, res_data, res_err};
         ok = 1'b1;
         repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            if ({res_valid, res_data, res_err} !== held) ok = 1'b0;
         end
         release_res(after);
         n_checks++;
         if ({ok, after, res_data, res_zero, res_neg} !== {1'b1, 2'b01, exp[7:2]})
            $display("FAIL b2b_hold_release: got %h want %h", {ok, after, res_data, res_zero, res_neg}, {1'b1, 2'b01, exp[7:2]});
         else n_pass++;
      end
   endtask

   initial begin
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_a = 4'd0; cmd_b = 4'd0; res_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      test_reset;
      test_alu_ops;
      test_mul;
      test_illegal;
      test_backpressure;
      test_back_to_back;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
